// File: rtl/param_sync_ram.sv
// param_sync_ram: single-port data memory with configurable width and depth,
// per-byte write enables, a selectable read-during-write result and a
// clear sequencer that sweeps every word to CLEAR_VALUE after reset.
// All state, including the array, updates on the falling edge of clk.
module param_sync_ram #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 7,
  parameter int                    RDW_MODE    = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    ready
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    ready_q, ready_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   old_word;
  logic [DATA_WIDTH-1:0]   merged_word;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  // Replace each enabled byte lane of the old word with the matching lane of the new data.
  function automatic logic [DATA_WIDTH-1:0] lane_merge(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [LANES-1:0]      lane_en
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < LANES; i++) begin
      if (lane_en[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // Next-state, array write port and read data selection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dout_d      = dout_q;
    ready_d     = ready_q;
    mem_we      = 1'b0;
    mem_addr    = address;
    mem_wdata   = data_in;
    old_word    = mem[address];
    merged_word = lane_merge(old_word, data_in, we ? be : '0);

    case (state_q)
      ST_CLEAR: begin
        // Sweep one word per edge; user inputs are ignored and data_out stays 0.
        mem_we    = ~reset;
        mem_addr  = cnt_q[ADDR_WIDTH-1:0];
        mem_wdata = CLEAR_VALUE;
        cnt_d     = cnt_q + 1'b1;
        dout_d    = '0;
        if (cnt_q[ADDR_WIDTH-1:0] == {ADDR_WIDTH{1'b1}}) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      default: begin
        // A write with no lanes enabled leaves the word untouched.
        mem_we    = we & (|be) & ~reset;
        mem_addr  = address;
        mem_wdata = merged_word;
        dout_d    = (RDW_MODE != 0) ? merged_word : old_word;
      end
    endcase
  end

  // Control and read-data registers; reset restarts the clear sweep immediately.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      dout_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
    end
  end

  // Storage array; contents are initialised by the sweep rather than by reset.
  always_ff @(negedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  assign data_out = dout_q;
  assign ready    = ready_q;

endmodule

// File: tb/tb_param_sync_ram.sv
// Bench for param_sync_ram: three instances (8-bit default, 32-bit old-data,
// 32-bit write-through with CLEAR_VALUE 0x5A) share one stimulus stream.
module tb_param_sync_ram;

  logic        clk;
  logic        reset;
  logic        we;
  logic [3:0]  be;
  logic [6:0]  addr;
  logic [31:0] din;

  logic [0:0]  be_a;
  logic [7:0]  din_a;
  logic [7:0]  dout_a;
  logic [31:0] dout_b, dout_c;
  logic        rdy_a, rdy_b, rdy_c;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  assign be_a  = be[0:0];
  assign din_a = din[7:0];

  param_sync_ram dut_a (
    .clk(clk), .reset(reset), .we(we), .be(be_a), .address(addr),
    .data_in(din_a), .data_out(dout_a), .ready(rdy_a)
  );

  param_sync_ram #(
    .DATA_WIDTH(32), .ADDR_WIDTH(7), .RDW_MODE(0), .CLEAR_VALUE(32'h0000005A)
  ) dut_b (
    .clk(clk), .reset(reset), .we(we), .be(be), .address(addr),
    .data_in(din), .data_out(dout_b), .ready(rdy_b)
  );

  param_sync_ram #(
    .DATA_WIDTH(32), .ADDR_WIDTH(7), .RDW_MODE(1), .CLEAR_VALUE(32'h0000005A)
  ) dut_c (
    .clk(clk), .reset(reset), .we(we), .be(be), .address(addr),
    .data_in(din), .data_out(dout_c), .ready(rdy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory contents as plain arrays, a count of words cleared.
  logic [7:0]  m_a [128];
  logic [31:0] m_b [128];
  int          m_cnt   = 0;
  bit          m_ready = 0;
  logic [7:0]  e_a = 8'h00;
  logic [31:0] e_b = 32'h0;
  logic [31:0] e_c = 32'h0;
  logic [7:0]  n_a;
  logic [31:0] n_b;

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      m_cnt = 0; m_ready = 0; e_a = 8'h00; e_b = 32'h0; e_c = 32'h0;
    end else if (!m_ready) begin
      m_a[m_cnt] = 8'h00;
      m_b[m_cnt] = 32'h5A;
      m_cnt++;
      if (m_cnt == 128) m_ready = 1;
    end else begin
      n_a = (we && be[0]) ? din[7:0] : m_a[addr];
      n_b = m_b[addr];
      for (int i = 0; i < 4; i++)
        if (we && be[i]) n_b[8*i +: 8] = din[8*i +: 8];
      e_a = m_a[addr];
      e_b = m_b[addr];
      e_c = n_b;
      m_a[addr] = n_a;
      m_b[addr] = n_b;
    end
  end

  // Per-cycle comparison on the rising edge, half a cycle away from updates.
  always @(posedge clk) begin
    if (chk_en) begin
      chk("cyc_ready_a", {31'b0, rdy_a}, {31'b0, m_ready});
      chk("cyc_ready_b", {31'b0, rdy_b}, {31'b0, m_ready});
      chk("cyc_ready_c", {31'b0, rdy_c}, {31'b0, m_ready});
      chk("cyc_dout_a", {24'b0, dout_a}, {24'b0, e_a});
      chk("cyc_dout_b", dout_b, e_b);
      chk("cyc_dout_c", dout_c, e_c);
    end
  end

  // Apply one access, let the falling edge take it, then settle.
  task automatic cyc(input logic w, input logic [3:0] b, input logic [6:0] a, input logic [31:0] d);
    we = w; be = b; addr = a; din = d;
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; be = 4'h0; addr = 7'd0; din = 32'h0;
    #12 chk_en = 1;
    cyc(1'b0, 4'h0, 7'd0, 32'h0);
    chk("rst_ready", {31'b0, rdy_a}, 32'h0);
    chk("rst_dout_b", dout_b, 32'h0);
    reset = 1'b0;

    // Partial sweep with writes attempted during CLEAR, then restart.
    for (int i = 0; i < 50; i++) cyc(1'b1, 4'hF, 7'd2, 32'hFFFF_FFFF);
    chk("mid_sweep_ready", {31'b0, rdy_b}, 32'h0);
    reset = 1'b1;
    cyc(1'b1, 4'hF, 7'd2, 32'hFFFF_FFFF);
    cyc(1'b1, 4'hF, 7'd2, 32'hFFFF_FFFF);
    reset = 1'b0;
    for (int i = 1; i <= 128; i++) begin
      cyc(1'b1, 4'hF, 7'd2, 32'hFFFF_FFFF);
      if (i == 127) chk("ready_127", {31'b0, rdy_a}, 32'h0);
      if (i == 127) chk("dout_clear", dout_c, 32'h0);
      if (i == 128) chk("ready_128", {29'b0, rdy_a, rdy_b, rdy_c}, 32'h7);
    end

    // Cleared contents.
    cyc(1'b0, 4'h0, 7'd0, 32'h0);   chk("rd0_a", {24'b0, dout_a}, 32'h00);
    cyc(1'b0, 4'h0, 7'd64, 32'h0);  chk("rd64_a", {24'b0, dout_a}, 32'h00);
    cyc(1'b0, 4'h0, 7'd127, 32'h0); chk("rd127_a", {24'b0, dout_a}, 32'h00);
    chk("rd127_b", dout_b, 32'h5A);
    cyc(1'b0, 4'h0, 7'd2, 32'h0);   chk("rd2_a", {24'b0, dout_a}, 32'h00);
    chk("rd2_b", dout_b, 32'h5A);

    // Simple write and read back.
    cyc(1'b1, 4'hF, 7'd5, 32'h0000_00A5);
    cyc(1'b0, 4'h0, 7'd5, 32'h0);   chk("rd5_a", {24'b0, dout_a}, 32'hA5);
    cyc(1'b0, 4'h0, 7'd6, 32'h0);   chk("rd6_a", {24'b0, dout_a}, 32'h00);

    // Byte-lane write and read-during-write in both modes.
    cyc(1'b1, 4'hF, 7'd3, 32'h1122_3344);
    cyc(1'b1, 4'b0101, 7'd3, 32'hAABB_CCDD);
    chk("rdw_old_b", dout_b, 32'h1122_3344);
    chk("rdw_new_c", dout_c, 32'h11BB_33DD);
    chk("rdw_old_a", {24'b0, dout_a}, 32'h44);
    cyc(1'b0, 4'h0, 7'd3, 32'h0);
    chk("lane_rd_b", dout_b, 32'h11BB_33DD);
    chk("lane_rd_a", {24'b0, dout_a}, 32'hDD);

    // Write with no lanes enabled.
    cyc(1'b1, 4'h0, 7'd3, 32'h0);
    chk("noop_c", dout_c, 32'h11BB_33DD);
    cyc(1'b0, 4'h0, 7'd3, 32'h0);
    chk("noop_rd_b", dout_b, 32'h11BB_33DD);

    // Overwrite a cleared word.
    cyc(1'b1, 4'hF, 7'd127, 32'h0);
    cyc(1'b0, 4'h0, 7'd127, 32'h0);
    chk("wr127_b", dout_b, 32'h0);

    // Reset during RUN drops ready at once.
    cyc(1'b0, 4'h0, 7'd5, 32'h0);
    reset = 1'b1;
    #1;
    chk("run_rst_ready", {29'b0, rdy_a, rdy_b, rdy_c}, 32'h0);
    chk("run_rst_dout", {24'b0, dout_a}, 32'h0);
    cyc(1'b0, 4'h0, 7'd0, 32'h0);
    reset = 1'b0;
    cyc(1'b0, 4'h0, 7'd0, 32'h0);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
